// File: rtl/tt_bist_pkg.sv
// Shared FSM state type, LFSR tap table and Galois step helper for the BIST harness.
// Pure types/constants; no timing of its own.
package tt_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   // Primitive-polynomial feedback masks, x^W term implied, indexed by register width.
   localparam logic [15:0] TAPS [4:16] = '{
      16'h0003,  // 4 : x^4+x+1
      16'h0005,  // 5 : x^5+x^2+1
      16'h0003,  // 6 : x^6+x+1
      16'h0003,  // 7 : x^7+x+1
      16'h001D,  // 8 : x^8+x^4+x^3+x^2+1
      16'h0011,  // 9 : x^9+x^4+1
      16'h0009,  // 10: x^10+x^3+1
      16'h0005,  // 11: x^11+x^2+1
      16'h0053,  // 12: x^12+x^6+x^4+x+1
      16'h001B,  // 13: x^13+x^4+x^3+x+1
      16'h002B,  // 14: x^14+x^5+x^3+x+1
      16'h0003,  // 15: x^15+x+1
      16'h6801   // 16: x^16+x^14+x^13+x^11+1
   };

   function automatic logic [15:0] step_w(input logic [15:0] x, input int w);
      logic [15:0] keep;
      keep = 16'((32'd1 << w) - 32'd1);
      return ((x << 1) & keep) ^ (x[w-1] ? TAPS[w] : 16'h0000);
   endfunction

endpackage

// File: rtl/tt_lfsr_step.sv
// One Galois LFSR/MISR register: load to INIT, or advance by step() XOR xor_i when enabled.
// Single-cycle update; holds when en_i and load_i are low.
module tt_lfsr_step
   import tt_bist_pkg::*;
#(
   parameter int           W    = 8,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   input  logic         load_i,
   input  logic [W-1:0] xor_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = INIT;
      end else if (en_i) begin
         q_d = W'(step_w(16'(q_q), W)) ^ xor_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_q <= INIT;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/tt_bist_harness.sv
// Drives PATTERNS LFSR vectors into a DUT, compacts LATENCY-delayed responses into a MISR, compares to a golden signature.
// ena low freezes every register; start is honoured only from IDLE or DONE.
module tt_bist_harness
   import tt_bist_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int PATTERNS = 256,
   parameter int LATENCY  = 1,
   parameter int SEED     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic [DATA_W-1:0] expected_sig,
   input  logic [DATA_W-1:0] resp_in,
   output logic [DATA_W-1:0] stim_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [DATA_W-1:0] sig_out
);

   localparam logic [15:0] LAST_CNT   = 16'(PATTERNS - 1);
   localparam logic [1:0]  DRAIN_LAST = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

   bist_state_t       state_q;
   logic [15:0]       cnt_q;
   logic [1:0]        drain_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;

   logic              start_ok;
   logic              run_vld;
   logic              misr_vld;
   logic [DATA_W-1:0] lfsr_q;
   logic [DATA_W-1:0] misr_q;
   logic [DATA_W-1:0] sig_fin;

   assign start_ok = ena && start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign run_vld  = (state_q == ST_RUN);

   tt_lfsr_step #(
      .W    (DATA_W),
      .INIT (DATA_W'(SEED))
   ) u_gen (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (ena && run_vld),
      .load_i  (start_ok),
      .xor_i   ('0),
      .q_o     (lfsr_q)
   );

   tt_lfsr_step #(
      .W    (DATA_W),
      .INIT ('0)
   ) u_misr (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (ena && misr_vld),
      .load_i  (start_ok),
      .xor_i   (resp_in),
      .q_o     (misr_q)
   );

   // Tracks which cycles carry a response belonging to a presented vector.
   generate
      if (LATENCY > 0) begin : g_vpipe
         logic [LATENCY-1:0] vpipe_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vpipe_q <= '0;
            end else if (ena) begin
               vpipe_q <= LATENCY'({vpipe_q, run_vld});
            end
         end
         assign misr_vld = vpipe_q[LATENCY-1];
      end else begin : g_nopipe
         assign misr_vld = run_vld;
      end
   endgenerate

   // The final MISR update lands on the same edge as DONE entry, so compare its next value.
   assign sig_fin = misr_vld ? (DATA_W'(step_w(16'(misr_q), DATA_W)) ^ resp_in) : misr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else if (ena) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  cnt_q   <= '0;
                  drain_q <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == LAST_CNT) begin
                  if (LATENCY > 0) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (sig_fin == expected_sig);
                  end
               end
            end
            ST_DRAIN: begin
               drain_q <= drain_q + 2'd1;
               if (drain_q == DRAIN_LAST) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (sig_fin == expected_sig);
               end
            end
         endcase
      end
   end

   assign stim_out = run_vld ? lfsr_q : '0;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign sig_out  = misr_q;

endmodule
